// File: rtl/pwm_tick_if.sv
// Bundle between the tick-driven PWM generator and its controller.
// The controller supplies the divided clock, the run request and the duty value; the generator returns its status.
interface pwm_tick_if #(
    parameter int WIDTH = 8
) ();
    logic             clkd;
    logic             en;
    logic [WIDTH-1:0] duty;
    logic             pwm;
    logic             period_done;
    logic             busy;

    modport master (
        output clkd, en, duty,
        input  pwm, period_done, busy
    );

    modport slave (
        input  clkd, en, duty,
        output pwm, period_done, busy
    );
endinterface

// File: rtl/pwm_tick_gen.sv
// PWM generator whose period counter advances on rising edges of the divider output clkd.
// clkd is sampled as data, and duty is shadowed at period boundaries. Define PWM_TICK_SYNC_EN to pass clkd through a 2-flop synchronizer.
module pwm_tick_gen #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    pwm_tick_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] duty_sh_reg, duty_sh_next;
    logic             period_done_reg, period_done_next;
    logic             pwm_reg;
    logic             clkd_q_reg;
    logic             clkd_s;
    logic             tick;

`ifdef PWM_TICK_SYNC_EN
    localparam int SYNC_STAGES = 2;
    logic [SYNC_STAGES-1:0] sync_reg;
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= bus.clkd;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate
    assign clkd_s = sync_reg[SYNC_STAGES-1];
`else
    assign clkd_s = bus.clkd;
`endif

    assign tick = clkd_s & ~clkd_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            duty_sh_reg     <= '0;
            period_done_reg <= 1'b0;
            pwm_reg         <= 1'b0;
            clkd_q_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            duty_sh_reg     <= duty_sh_next;
            period_done_reg <= period_done_next;
            clkd_q_reg      <= clkd_s;
            pwm_reg         <= (state_reg == RUN) && (cnt_reg < duty_sh_reg);
        end
    end

    // A stop request is honoured only on the wrap, so a period always runs to completion.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        duty_sh_next     = duty_sh_reg;
        period_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.en) begin
                    state_next   = RUN;
                    duty_sh_next = bus.duty;
                end
            end
            RUN: begin
                if (tick) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_MAX) begin
                        duty_sh_next     = bus.duty;
                        period_done_next = 1'b1;
                        if (!bus.en) state_next = IDLE;
                    end
                end
            end
        endcase
    end

    assign bus.pwm         = pwm_reg;
    assign bus.period_done = period_done_reg;
    assign bus.busy        = (state_reg == RUN);
endmodule

// File: tb/tb_pwm_tick_gen.sv
// Randomized scoreboard bench for pwm_tick_gen.
// The driver pushes the expected high-tick count of each period, and the monitor pops one entry at every period_done.
module tb_pwm_tick_gen;
    localparam int WIDTH        = 8;
    localparam int PERIOD_TICKS = 1 << WIDTH;
`ifdef PWM_TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    pwm_tick_if #(.WIDTH(WIDTH)) bus ();

    pwm_tick_gen #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int exp_q[$];

    // Reference model: tick position within the period and the running flag.
    int m_tick        = 0;
    bit m_running     = 1'b0;
    int n_exp_periods = 0;

    int periods_checked = 0;
    int acc_n  = 0;
    int acc_hi = 0;
    bit prev_clkd = 1'b0;
    bit busy_prev = 1'b0;
    bit pd_prev   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_tick();
        if (m_running) begin
            m_tick++;
            if (m_tick == PERIOD_TICKS) begin
                m_tick = 0;
                n_exp_periods++;
                if (bus.en) exp_q.push_back(int'(bus.duty));
                else        m_running = 1'b0;
            end
        end
    endtask

    task automatic do_tick();
        int gap;
        gap = $urandom_range(3, 5);
        model_tick();
        @(posedge clk); #1 bus.clkd = 1'b1;
        @(posedge clk); #1 bus.clkd = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic start_run(input int d);
        bus.duty = d[WIDTH-1:0];
        bus.en   = 1'b1;
        @(posedge clk); #1;
        m_running = 1'b1;
        m_tick    = 0;
        exp_q.push_back(d);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Each rising clkd edge samples pwm while the counter still holds the value that edge will advance.
    always @(negedge clk) begin
        if (rst) begin
            acc_n     = 0;
            acc_hi    = 0;
            prev_clkd = bus.clkd;
            busy_prev = 1'b0;
            pd_prev   = 1'b0;
        end else begin
            if (bus.clkd && !prev_clkd && bus.busy) begin
                acc_n++;
                if (bus.pwm) acc_hi++;
            end
            prev_clkd = bus.clkd;
            if (!bus.busy && !busy_prev) check("pwm_idle", int'(bus.pwm), 0);
            if (bus.period_done) begin
                check("pd_width", int'(pd_prev), 0);
                if (exp_q.size() == 0) begin
                    check("pd_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    periods_checked++;
                    $display("period %0d: expected high %0d, got high %0d over %0d ticks",
                             periods_checked, e, acc_hi, acc_n);
                    check("period_high", acc_hi, e);
                    check("period_ticks", acc_n, PERIOD_TICKS);
                end
                acc_n  = 0;
                acc_hi = 0;
            end
            busy_prev = bus.busy;
            pd_prev   = bus.period_done;
        end
    end

    initial begin
        int stop_at;
        rst      = 1'b1;
        bus.clkd = 1'b0;
        bus.en   = 1'b1;
        bus.duty = 8'h80;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_pwm", int'(bus.pwm), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_pd", int'(bus.period_done), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_rst", int'(bus.busy), 1);
        m_running = 1'b1;
        m_tick    = 0;
        exp_q.push_back(128);
        #1;

        // 50 %, then 0, then 255, two periods each.
        run_ticks(500); bus.duty = 8'd0;   run_ticks(12);
        run_ticks(500); bus.duty = 8'd255; run_ticks(12);
        run_ticks(500); bus.duty = 8'd64;  run_ticks(12);
        // Shadow update: mid-period change only affects the next period.
        run_ticks(10);  bus.duty = 8'd192; run_ticks(246);
        run_ticks(200); bus.duty = 8'd128; run_ticks(56);
        // Graceful stop requested at tick 100.
        run_ticks(100); bus.en = 1'b0;     run_ticks(156);
        @(negedge clk);
        check("busy_after_stop", int'(bus.busy), int'(m_running));
        check("pwm_after_stop", int'(bus.pwm), 0);
        #1;
        run_ticks(3);
        @(negedge clk);
        check("busy_idle_ticks", int'(bus.busy), 0);
        #1;

        // Tick latency: duty 1 drops pwm one cycle after the counter leaves 0.
        start_run(1);
        model_tick();
        @(posedge clk); #1 bus.clkd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("latency_pwm", int'(bus.pwm), (i < 2 + LAT) ? 1 : 0);
        end
        @(posedge clk); #1 bus.clkd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_ticks(PERIOD_TICKS - 1);

        // Random duty changes over three periods, stop requested somewhere in the last.
        stop_at = 2 * PERIOD_TICKS + $urandom_range(0, PERIOD_TICKS - 1);
        for (int t = 0; t < 3 * PERIOD_TICKS; t++) begin
            if ($urandom_range(0, 31) == 0) bus.duty = 8'($urandom_range(0, 255));
            if (t == stop_at) bus.en = 1'b0;
            do_tick();
        end
        @(negedge clk);
        check("busy_after_rand_stop", int'(bus.busy), int'(m_running));
        #1;

        // Reset in the middle of a period.
        start_run($urandom_range(1, 255));
        run_ticks(50);
        check("periods_seen", periods_checked, n_exp_periods);
        check("queue_depth", exp_q.size(), 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_pwm", int'(bus.pwm), 0);
        check("midrst_pd", int'(bus.period_done), 0);
        rst    = 1'b0;
        bus.en = 1'b0;
        exp_q.delete();
        m_running = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_after_midrst", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
